// File: rtl/program_loader.sv
// Byte-stream program loader: assembles big-endian 32-bit words from a host link
//   and writes them into program memory at BASE_ADDRESS + 4*index.
// Latency: mem_write pulses the cycle after the 4th byte of a word is accepted.
// Backpressure: byte_ready drops during the one-cycle WRITE state (5 cycles/word minimum).
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               begins a load (honoured in IDLE, DONE, ERROR only)
//   byte_valid/ready    byte stream handshake; byte_data is the stream byte
//   mem_write/address/data  program memory write port (address/data valid with mem_write)
//   busy, done, error   load status (done/error sticky until next start or reset)
//   words_written       words written in the current or last load
module program_loader #(
  parameter int                  MEMORY_DEPTH = 32,
  parameter int                  DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_written
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] HDR_HI = 3'd1;
  localparam logic [2:0] HDR_LO = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] ERROR  = 3'd6;

  logic [2:0]  state;
  logic [2:0]  nxt;
  logic [15:0] count;
  logic [15:0] index;
  logic [1:0]  byte_cnt;
  logic [31:0] word;
  logic [31:0] word_nxt;
  logic [15:0] hdr_full;
  logic        acc;
  logic        start_ok;

  assign acc      = byte_valid && byte_ready;
  assign start_ok = start && (state == IDLE || state == DONE || state == ERROR);
  assign word_nxt = {word[23:0], byte_data};
  assign hdr_full = {count[15:8], byte_data};

  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERROR: if (start) nxt = HDR_HI;
      HDR_HI: if (acc) nxt = HDR_LO;
      HDR_LO: begin
        if (acc) begin
          if (hdr_full == 16'd0)                     nxt = DONE;
          else if (hdr_full > 16'(MEMORY_DEPTH))     nxt = ERROR;
          else                                       nxt = DATA;
        end
      end
      DATA:  if (acc && byte_cnt == 2'd3) nxt = WRITE;
      WRITE: nxt = (index + 16'd1 == count) ? DONE : DATA;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      count         <= '0;
      index         <= '0;
      byte_cnt      <= '0;
      word          <= '0;
      byte_ready    <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_data      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
    end else begin
      state <= nxt;
      // Status outputs are registered from the next state so they line up with it.
      byte_ready <= (nxt == HDR_HI) || (nxt == HDR_LO) || (nxt == DATA);
      busy       <= (nxt == HDR_HI) || (nxt == HDR_LO) || (nxt == DATA) || (nxt == WRITE);
      done       <= (nxt == DONE);
      error      <= (nxt == ERROR);
      mem_write  <= (nxt == WRITE);

      if (start_ok) begin
        index         <= '0;
        words_written <= '0;
      end

      case (state)
        HDR_HI: if (acc) count[15:8] <= byte_data;
        HDR_LO: begin
          if (acc) begin
            count[7:0] <= byte_data;
            byte_cnt   <= '0;
            index      <= '0;
          end
        end
        DATA: begin
          if (acc) begin
            word     <= word_nxt;
            byte_cnt <= byte_cnt + 2'd1;
            // Address and data are captured here so they are valid alongside mem_write.
            if (byte_cnt == 2'd3) begin
              mem_address <= BASE_ADDRESS + (DATA_WIDTH'(index) << 2);
              mem_data    <= DATA_WIDTH'(word_nxt);
            end
          end
        end
        WRITE: begin
          index         <= index + 16'd1;
          words_written <= words_written + 16'd1;
          byte_cnt      <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_written;

  program_loader dut (
    .clk(clk), .reset(reset), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_write(mem_write), .mem_address(mem_address), .mem_data(mem_data),
    .busy(busy), .done(done), .error(error), .words_written(words_written)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Observed write strobes and the cycle each was seen in.
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          wc[$];
  // Words the reference model expects to be written, in order.
  logic [31:0] exp_w[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_write) begin
      wa.push_back(mem_address);
      wd.push_back(mem_data);
      wc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offers one byte, optionally after random idle cycles, and waits until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int  guard;
    logic took;
    while ($urandom_range(99) < gap_pct) begin
      byte_valid = 1'b0;
      tick();
    end
    byte_valid = 1'b1;
    byte_data  = b;
    took  = 1'b0;
    guard = 0;
    while (!took && guard < 200) begin
      took = byte_ready;
      tick();
      guard++;
    end
    if (!took) check("byte_timeout", 32'd0, 32'd1);
    byte_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] n, input int gap_pct);
    send_byte(n[15:8], gap_pct);
    send_byte(n[7:0], gap_pct);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_pct);
    for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8], gap_pct);
  endtask

  task automatic wait_end(input string tag);
    int g;
    g = 0;
    while (!(done || error) && g < 3000) begin
      tick();
      g++;
    end
    check({tag, "_finished"}, {31'd0, done || error}, 32'd1);
  endtask

  // Compares captured writes against the model: word i at BASE + 4*i.
  task automatic verify_writes(input string tag);
    check({tag, "_nwrites"}, wa.size(), exp_w.size());
    for (int i = 0; i < exp_w.size(); i++) begin
      if (i < wa.size()) begin
        check($sformatf("%s_addr%0d", tag, i), wa[i], BASE + 32'(i) * 32'd4);
        check($sformatf("%s_data%0d", tag, i), wd[i], exp_w[i]);
      end
    end
  endtask

  // Full load of exp_w with the given gap probability, then outcome checks.
  task automatic run_load(input string tag, input int gap_pct);
    wa.delete(); wd.delete(); wc.delete();
    pulse_start();
    send_hdr(16'(exp_w.size()), gap_pct);
    foreach (exp_w[i]) send_word(exp_w[i], gap_pct);
    wait_end(tag);
    verify_writes(tag);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
    check({tag, "_count"}, {16'd0, words_written}, exp_w.size());
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_flags"}, {26'd0, byte_ready, mem_write, busy, done, error, 1'b0}, 32'd0);
    check({tag, "_addr"}, mem_address, 32'd0);
    check({tag, "_data"}, mem_data, 32'd0);
    check({tag, "_ww"}, {16'd0, words_written}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    tick(); tick();
    reset = 1'b0;
    check_idle_outputs("reset");

    // Two known words, byte_valid held high; strobes must be 5 cycles apart.
    exp_w = '{32'h2408_0005, 32'h2009_0007};
    run_load("basic", 0);
    if (wc.size() == 2) check("basic_spacing", wc[1] - wc[0], 32'd5);
    else check("basic_spacing_n", wc.size(), 32'd2);

    // Header one past the memory depth: error, no writes.
    wa.delete(); wd.delete(); wc.delete();
    pulse_start();
    send_hdr(16'd33, 0);
    wait_end("ovf");
    check("ovf_error", {31'd0, error}, 32'd1);
    check("ovf_busy", {31'd0, busy}, 32'd0);
    check("ovf_ready", {31'd0, byte_ready}, 32'd0);
    check("ovf_done", {31'd0, done}, 32'd0);
    repeat (5) tick();
    check("ovf_nwrites", wa.size(), 32'd0);

    // Recovery from error with a single zero word.
    exp_w = '{32'h0000_0000};
    run_load("recover", 0);

    // Empty load: done right after the second header byte, nothing written.
    wa.delete(); wd.delete(); wc.delete();
    pulse_start();
    send_hdr(16'd0, 0);
    check("empty_done", {31'd0, done}, 32'd1);
    check("empty_busy", {31'd0, busy}, 32'd0);
    check("empty_ww", {16'd0, words_written}, 32'd0);
    repeat (3) tick();
    check("empty_nwrites", wa.size(), 32'd0);

    // Full-depth load of random words with random valid gaps.
    exp_w.delete();
    for (int i = 0; i < 32; i++) exp_w.push_back($urandom);
    run_load("full", 50);

    // Reset in the middle of the third word.
    exp_w.delete();
    for (int i = 0; i < 5; i++) exp_w.push_back($urandom);
    pulse_start();
    send_hdr(16'd5, 0);
    send_word(exp_w[0], 0);
    send_word(exp_w[1], 0);
    send_byte(exp_w[2][31:24], 0);
    send_byte(exp_w[2][23:16], 0);
    wa.delete(); wd.delete(); wc.delete();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_outputs("midrst");
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    repeat (10) tick();
    byte_valid = 1'b0;
    check("midrst_nwrites", wa.size(), 32'd0);
    check("midrst_ready", {31'd0, byte_ready}, 32'd0);
    exp_w = '{$urandom, $urandom};
    run_load("afterrst", 0);

    // start during DATA is ignored.
    exp_w = '{$urandom, $urandom, $urandom};
    wa.delete(); wd.delete(); wc.delete();
    pulse_start();
    send_hdr(16'd3, 0);
    send_byte(exp_w[0][31:24], 0);
    send_byte(exp_w[0][23:16], 0);
    pulse_start();
    send_byte(exp_w[0][15:8], 0);
    send_byte(exp_w[0][7:0], 0);
    send_word(exp_w[1], 25);
    pulse_start();
    send_word(exp_w[2], 25);
    wait_end("midstart");
    verify_writes("midstart");
    check("midstart_ww", {16'd0, words_written}, 32'd3);

    // start in DONE relaunches: done clears, busy rises.
    pulse_start();
    check("restart_done", {31'd0, done}, 32'd0);
    check("restart_busy", {31'd0, busy}, 32'd1);
    check("restart_ww", {16'd0, words_written}, 32'd0);
    send_hdr(16'd0, 0);
    check("restart_end", {31'd0, done}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer-side counterpart to the instruction-memory read path.
- Accepts a byte stream from a host link (e.g. UART RX) and assembles big-endian 32-bit instruction words.
- Writes each word into a writable program memory at word-aligned byte addresses starting at BASE_ADDRESS. The fetch side then reads them using Address[..:2] word indexing.
- Sits between the serial receiver and the program memory write port; the CPU is held off while busy=1.

Parameters:
- MEMORY_DEPTH, 32: number of 32-bit words in the target program memory; the maximum loadable word count.
- DATA_WIDTH, 32: word and address width.
- BASE_ADDRESS, 32'h0040_0000: byte address of word 0 (MIPS text segment base).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- byte_valid  input  1  byte_data holds a valid byte.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader can accept a byte this cycle.
- mem_write  output  1  one-cycle write strobe to program memory.
- mem_address  output  DATA_WIDTH  byte address for the write; always a multiple of 4.
- mem_data  output  DATA_WIDTH  assembled instruction word.
- busy  output  1  load in progress.
- done  output  1  load completed successfully; sticky.
- error  output  1  header word count exceeded MEMORY_DEPTH; sticky.
- words_written  output  16  count of words written in the current or last load.

Behaviour:
- Reset: synchronous, active-high. It overrides everything, including mid-load. State goes to IDLE and all outputs, the byte counter and the word index are cleared to 0. No mem_write is issued on or after the reset edge.
- Handshake: a byte is accepted on a rising edge where byte_valid && byte_ready. byte_ready is a registered function of state: 1 in HDR_HI, HDR_LO and DATA; 0 otherwise.
- Stream format: 2-byte word count N (MSB first), then 4N data bytes, each word MSB first.
- States and transitions:
  - IDLE: start -> HDR_HI.
  - HDR_HI: accept byte -> N[15:8]; go to HDR_LO.
  - HDR_LO: accept byte -> N[7:0]. Then:
    - N==0 -> DONE.
    - N>MEMORY_DEPTH -> ERROR.
    - otherwise -> DATA with byte_cnt=0 and index=0.
  - DATA: each accepted byte does word = {word[23:0], byte_data} and byte_cnt++. Acceptance of the 4th byte -> WRITE.
  - WRITE: lasts exactly one cycle.
    - mem_write=1, mem_address=BASE_ADDRESS + (index<<2), mem_data=word.
    - index++, words_written++.
    - If index+1==N -> DONE; else -> DATA with byte_cnt=0.
  - DONE: done=1, busy=0. start -> HDR_HI, clearing done, index and words_written.
  - ERROR: error=1, busy=0, no writes. start -> HDR_HI, clearing error; only reset or start exits.
- busy=1 in HDR_HI, HDR_LO, DATA and WRITE.
- Latency: mem_write is high in the cycle immediately after the edge that accepted the 4th byte of a word.
- Back-pressure: byte_ready=0 during WRITE, so the minimum is 5 cycles per word. byte_valid held during WRITE is not consumed.
- Gaps: byte_valid may drop at any point; the loader waits in its current state indefinitely.
- start pulses in HDR_HI, HDR_LO, DATA or WRITE are ignored.
- Address arithmetic: modulo 2^DATA_WIDTH. The last address is BASE_ADDRESS + 4*(N-1) and never exceeds BASE_ADDRESS + 4*(MEMORY_DEPTH-1).
- mem_address and mem_data hold their last values when mem_write=0. Consumers must qualify them with mem_write.

Test Plan:
- Reset, then start and stream 00 02 | 24 08 00 05 | 20 09 00 07, byte_valid held high -> two mem_write pulses: 0x00400000/0x24080005, then 0x00400004/0x20090007. Then done=1, busy=0, words_written=2, and exactly 5 cycles between the two strobes.
- Header 00 21 with MEMORY_DEPTH=32 -> error=1, busy=0, byte_ready=0, and no mem_write. Then start plus header 00 01 and word 00 00 00 00 -> error clears, one write to 0x00400000.
- Header 00 00 -> DONE two accepted bytes after start, no mem_write, words_written=0.
- Random byte_valid gaps (50% duty) over a 32-word load -> 32 writes at 0x00400000..0x0040007C. Data matches the stream exactly and no byte is lost or duplicated across WRITE cycles.
- Assert reset for 1 cycle after byte 2 of word 3 -> no further mem_write, all outputs 0, state IDLE. A fresh load then restarts at 0x00400000.
- Pulse start during DATA -> ignored, load completes unchanged. Pulse start while in DONE -> done drops next cycle, busy=1.
